ifm_buf_wr: RTL
===============

Name: ifm_buf_wr

Overview:
- System-side writer for the IFM ping-pong buffer.
- Accepts a valid/ready stream of IFM words and writes one tile into whichever bank the ping-pong pointer selects.
- Emits the sys_wr_start and sys_wr_end pulses consumed by ifm_chn_sel, and stalls while the target bank is still occupied according to ifm_buf_state.

Parameters:
- DATA_W, 64, width of one IFM buffer word (8 lanes x 8 bit).
- ADDR_W, 8, buffer bank address width; bank depth is 2^ADDR_W words.

Ports:
- clock  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- cfg_words  in  ADDR_W  words per tile; 0 means 2^ADDR_W; sampled at tile start
- s_valid  in  1  input word valid
- s_data  in  DATA_W  input word
- s_last  in  1  producer marks final word of tile (checked only)
- s_ready  out  1  writer accepts word this cycle
- ifm_buf_state  in  2  from ifm_chn_sel; bit b=1 means bank b is written and not yet released by the reader
- buf_wr_en  out  1  bank write strobe
- buf_wr_bank  out  1  bank select
- buf_wr_addr  out  ADDR_W  word address within bank
- buf_wr_data  out  DATA_W  write data
- sys_wr_start  out  1  one-cycle pulse: tile write begins
- sys_wr_end  out  1  one-cycle pulse: tile fully written
- err_len  out  1  sticky: s_last position disagreed with cfg_words

Behaviour:
- Reset values (all outputs registered): s_ready=0, buf_wr_en=0, buf_wr_bank=0, buf_wr_addr=0, buf_wr_data=0, sys_wr_start=0, sys_wr_end=0, err_len=0. Internal wr_ptr=0, cnt=0, state IDLE.
- FSM states: IDLE, WAIT_BANK, WRITE, DONE.
- IDLE: on s_valid=1 -> WAIT_BANK. No data is accepted.
- WAIT_BANK: stays while ifm_buf_state[wr_ptr]=1.
  - When the bit is 0: latch len_q = cfg_words (0 -> 2^ADDR_W), clear cnt, pulse sys_wr_start for exactly one cycle, -> WRITE.
  - s_ready goes high the cycle after sys_wr_start and never coincides with it.
- WRITE: s_ready=1.
  - Each beat with s_valid&s_ready, at edge k, produces in the following cycle: buf_wr_en=1, buf_wr_bank=wr_ptr, buf_wr_addr=cnt, buf_wr_data=s_data. cnt then increments.
  - Write latency is 1 cycle. Gaps in s_valid give buf_wr_en=0 and hold cnt.
  - When the accepted beat has cnt=len_q-1: s_ready drops to 0 from that edge (no further beat is accepted), -> DONE.
- DONE: one cycle; the final buf_wr_en is high here.
  - sys_wr_end pulses high the next cycle (one cycle after the last buf_wr_en).
  - wr_ptr toggles, -> IDLE.
- Ping-pong ordering: banks are written strictly 0,1,0,1,...
  - A tile arriving while its bank is occupied waits indefinitely in WAIT_BANK with s_ready=0.
  - ifm_buf_state changes during WRITE are ignored; the bank is owned from sys_wr_start to sys_wr_end.
- Length check:
  - err_len sets if s_last=1 on an accepted beat with cnt != len_q-1.
  - err_len also sets if s_last=0 on the beat with cnt = len_q-1.
  - err_len clears only on reset. The tile length is always len_q, never s_last.
- cnt width is ADDR_W+1, so a full-depth tile does not wrap before the compare.
- Back-to-back tiles: if s_valid is high when IDLE is re-entered, the path is IDLE -> WAIT_BANK on the next edge. Minimum gap from sys_wr_end to the next sys_wr_start is 2 cycles.
- cfg_words changes after latching have no effect on the current tile.
- Reset mid-tile: everything returns to reset values and no sys_wr_end is issued. ifm_chn_sel is reset by the same rst_n, so both sides restart at bank 0.

Test Plan:
- Reset, cfg_words=4, continuous 4 words D0..D3 with ifm_buf_state=00 -> one sys_wr_start pulse; buf_wr_en on 4 consecutive cycles, bank 0, addr 0..3, data D0..D3; sys_wr_end one cycle after the last write; err_len=0.
- Second tile with ifm_buf_state=01 -> writes go to bank 1, addr 0..3. Third tile while ifm_buf_state=01 -> held in WAIT_BANK with s_ready=0 until bit0 clears, then sys_wr_start and writes to bank 0.
- cfg_words=4 with s_valid toggling 1,0,1,0,... -> buf_wr_en only on cycles after accepted beats, addresses contiguous 0..3, exactly 4 writes, single sys_wr_end.
- cfg_words=0, ADDR_W=8 -> 256 writes, addr 0..255, no early termination at 255->0; s_last on word 255 gives err_len=0.
- cfg_words=4 with s_last on beat 2 -> err_len=1 and stays 1. The tile still takes 4 beats and ends with sys_wr_end.
- Assert rst_n=0 for one cycle after beat 2 of a 4-word tile -> no sys_wr_end; all outputs 0. The next tile starts on bank 0 at addr 0.

Source files
------------

// File: rtl/ifm_buf_wr.sv
// System-side writer for the IFM ping-pong buffer: takes a valid/ready word
// stream and writes one tile into the bank selected by the ping-pong pointer.
module ifm_buf_wr #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8
) (
    input  logic              clock_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] cfg_words_i,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    input  logic [1:0]        ifm_buf_state_i,
    output logic              buf_wr_en_o,
    output logic              buf_wr_bank_o,
    output logic [ADDR_W-1:0] buf_wr_addr_o,
    output logic [DATA_W-1:0] buf_wr_data_o,
    output logic              sys_wr_start_o,
    output logic              sys_wr_end_o,
    output logic              err_len_o
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BANK,
        WRITE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic                s_ready_q, s_ready_d;
    logic                wr_en_q, wr_en_d;
    logic                wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                start_q, start_d;
    logic                end_q, end_d;
    logic                err_q, err_d;

    logic                accept;
    logic                last_beat;

    assign accept    = s_valid_i & s_ready_q;
    // cnt is one bit wider than the address so a full-depth tile compares
    // against 2^ADDR_W-1 without wrapping.
    assign last_beat = (cnt_q == (len_q - CNT_W'(1)));

    always_ff @(posedge clock_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            wr_ptr_q  <= 1'b0;
            cnt_q     <= '0;
            len_q     <= '0;
            s_ready_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            start_q   <= 1'b0;
            end_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            s_ready_q <= s_ready_d;
            wr_en_q   <= wr_en_d;
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            start_q   <= start_d;
            end_q     <= end_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        s_ready_d = s_ready_q;
        wr_en_d   = 1'b0;
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        start_d   = 1'b0;
        end_d     = 1'b0;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                s_ready_d = 1'b0;
                if (s_valid_i) begin
                    state_d = WAIT_BANK;
                end
            end

            WAIT_BANK: begin
                s_ready_d = 1'b0;
                if (!ifm_buf_state_i[wr_ptr_q]) begin
                    len_d   = (cfg_words_i == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                  : {1'b0, cfg_words_i};
                    cnt_d   = '0;
                    start_d = 1'b1;
                    state_d = WRITE;
                end
            end

            WRITE: begin
                // ready is still low in the sys_wr_start cycle, rises one later
                s_ready_d = 1'b1;
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_bank_d = wr_ptr_q;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = s_data_i;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        s_ready_d = 1'b0;
                        state_d   = DONE;
                        if (!s_last_i) begin
                            err_d = 1'b1;
                        end
                    end else if (s_last_i) begin
                        err_d = 1'b1;
                    end
                end
            end

            DONE: begin
                s_ready_d = 1'b0;
                end_d     = 1'b1;
                wr_ptr_d  = ~wr_ptr_q;
                state_d   = IDLE;
            end

            default: begin
                state_d   = IDLE;
                s_ready_d = 1'b0;
            end
        endcase
    end

    assign s_ready_o      = s_ready_q;
    assign buf_wr_en_o    = wr_en_q;
    assign buf_wr_bank_o  = wr_bank_q;
    assign buf_wr_addr_o  = wr_addr_q;
    assign buf_wr_data_o  = wr_data_q;
    assign sys_wr_start_o = start_q;
    assign sys_wr_end_o   = end_q;
    assign err_len_o      = err_q;

endmodule
